// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port among NREQ writeback sources
// (ALU, load unit, mul/div, ...). Each cycle it grants one source in
// round-robin order, and one edge later it drives the registered write
// enable, address and data into the register file. It also keeps a
// per-register pending mask. The issue logic uses this mask to stall readers
// of registers whose results have not yet been written back.
//
// Ports:
//   clk, rst    - clock (rising edge); asynchronous active-high reset
//   req_valid   - [NREQ]   per-requester write request
//   req_addr    - [5*NREQ] destination register, requester i at [5i+4:5i]
//   req_data    - [N*NREQ] write data, requester i at [Ni+N-1:Ni]
//   req_ready   - [NREQ]   combinational one-hot grant (zero during reset)
//   rsv_valid   - issue logic reserves rsv_addr this cycle
//   rsv_addr    - [5] register being reserved
//   rf_we       - registered register-file write enable
//   rf_waddr    - [5] registered register-file write address
//   rf_wdata    - [N] registered register-file write data
//   pending     - [32] outstanding-write mask; bit 0 is always 0
//
// Handshake: a write transfers on any cycle where req_valid[i] and
// req_ready[i] are both high. The requester keeps valid, addr and data
// stable until it sees ready, and it never drops valid before acceptance.
// The grant depends only on req_valid and the round-robin pointer.

module regfile_wb_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  input  logic [N*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              rsv_valid,
  input  logic [4:0]        rsv_addr,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [N-1:0]      rf_wdata,
  output logic [31:0]       pending
);

  // Round-robin pointer: the requester with top priority this cycle.
  logic [1:0]   ptr;
  logic [1:0]   ptr_next;
  logic         grant_found;
  int           g_int;
  logic [4:0]   g_addr;
  logic [N-1:0] g_data;
  logic         transfer;
  logic [31:0]  pending_q;
  logic [31:0]  pending_next;

  // Scan the priority slots ptr, ptr+1, ... (mod NREQ). The first valid
  // requester wins. The inner loop over i keeps every select index constant.
  always_comb begin
    grant_found = 1'b0;
    g_int       = 0;
    g_addr      = '0;
    g_data      = '0;
    ptr_next    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && (i == (int'(ptr) + k) % NREQ) && req_valid[i]) begin
          grant_found = 1'b1;
          g_int       = i;
          g_addr      = req_addr[5*i +: 5];
          g_data      = req_data[N*i +: N];
          ptr_next    = (i == NREQ - 1) ? 2'd0 : 2'(i + 1);
        end
      end
    end
  end

  // Grant is suppressed while reset is asserted. A grant therefore always
  // means a transfer, because the winner is valid by construction.
  assign transfer = grant_found && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = transfer && (g_int == i);
    end
  end

  // Scoreboard update. The set is applied after the clear, so a reservation
  // in the same cycle as the writeback of the same register wins: the new
  // reservation is younger than the write being retired.
  always_comb begin
    pending_next = pending_q;
    if (transfer) begin
      pending_next[g_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      pending_next[rsv_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 2'd0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= '0;
      pending_q <= '0;
    end else begin
      // A write to x0 is accepted and advances ptr, but it never reaches
      // the register file.
      rf_we     <= transfer && (g_addr != 5'd0);
      pending_q <= pending_next;
      if (transfer) begin
        rf_waddr <= g_addr;
        rf_wdata <= g_data;
        ptr      <= ptr_next;
      end
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter (N=32, NREQ=3).
// Each table row is applied for one cycle. req_ready is checked before the
// edge, and the registered outputs and pending are checked after the edge.
// A hand-written sequence covers the asynchronous reset taken mid-cycle.

module tb_regfile_wb_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 3;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [5*NREQ-1:0] req_addr  = '0;
  logic [N*NREQ-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsv_valid = 1'b0;
  logic [4:0]        rsv_addr  = '0;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [N-1:0]      rf_wdata;
  logic [31:0]       pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pending   (pending)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        rv;
    logic [4:0]  ra;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vq[$];

  int tests  = 0;
  int failed = 0;

  // Scoreboard of expected {waddr, wdata} register-file writes.
  logic [36:0] exp_q[$];

  task automatic add_vec(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                         input logic rv, input logic [4:0] ra, input logic [2:0] er,
                         input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic [31:0] ep);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.rv = rv; t.ra = ra;
    t.e_ready = er; t.e_we = ew; t.e_waddr = ea; t.e_wdata = ed; t.e_pend = ep;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare an observed register-file write against the scoreboard.
  task automatic sb_check(input string name);
    logic [36:0] e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL %s_sb: got write %0h/%0h expected no write", name, rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_sb"}, {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t t);
    req_valid = t.valid;
    req_addr  = t.addr;
    req_data  = t.data;
    rsv_valid = t.rv;
    rsv_addr  = t.ra;
  endtask

  localparam logic [14:0] A3 = {5'd7, 5'd6, 5'd5};
  localparam logic [95:0] D3 = {32'hC, 32'hB, 32'hA};

  initial begin
    vec_t t;
    string nm;

    // Round-robin under full contention.
    add_vec(3'b111, A3, D3, 0, 0, 3'b001, 1, 5, 32'hA, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b010, 1, 6, 32'hB, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b100, 1, 7, 32'hC, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b001, 1, 5, 32'hA, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b010, 1, 6, 32'hB, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b100, 1, 7, 32'hC, 0);
    // Single requester 2, then idle, then contention starts at requester 0.
    add_vec(3'b100, {5'd3, 10'd0}, {32'h1234, 64'd0}, 0, 0, 3'b100, 1, 3, 32'h1234, 0);
    add_vec(3'b000, 15'd0, 96'd0, 0, 0, 3'b000, 0, 3, 32'h1234, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b001, 1, 5, 32'hA, 0);
    // Requester 1 writes x0: accepted, no rf_we, ptr moves to 2.
    add_vec(3'b010, 15'd0, {32'd0, 32'hFFFF_FFFF, 32'd0}, 0, 0, 3'b010, 0, 0, 32'hFFFF_FFFF, 0);
    add_vec(3'b111, A3, D3, 0, 0, 3'b100, 1, 7, 32'hC, 0);
    // Scoreboard: reserve 9, reserve x0 (ignored), then write 9.
    add_vec(3'b000, 15'd0, 96'd0, 1, 9, 3'b000, 0, 7, 32'hC, 32'h0000_0200);
    add_vec(3'b000, 15'd0, 96'd0, 1, 0, 3'b000, 0, 7, 32'hC, 32'h0000_0200);
    add_vec(3'b001, {10'd0, 5'd9}, {64'd0, 32'h99}, 0, 0, 3'b001, 1, 9, 32'h99, 0);
    // Same-cycle set and clear.
    add_vec(3'b000, 15'd0, 96'd0, 1, 12, 3'b000, 0, 9, 32'h99, 32'h0000_1000);
    add_vec(3'b010, {5'd0, 5'd12, 5'd0}, {32'd0, 32'h12, 32'd0}, 1, 12, 3'b010, 1, 12, 32'h12, 32'h0000_1000);
    add_vec(3'b100, {5'd12, 10'd0}, {32'h21, 64'd0}, 1, 13, 3'b100, 1, 12, 32'h21, 32'h0000_2000);
    // Requester 1 held valid while 0 wins, then 1 wins next cycle.
    add_vec(3'b011, {5'd0, 5'd20, 5'd13}, {32'd0, 32'h20, 32'h13}, 0, 0, 3'b001, 1, 13, 32'h13, 0);
    add_vec(3'b011, {5'd0, 5'd20, 5'd13}, {32'd0, 32'h20, 32'h13}, 0, 0, 3'b010, 1, 20, 32'h20, 0);

    // Initial reset state, with requests already present.
    req_valid = 3'b111; req_addr = A3; req_data = D3;
    #3;
    chk("init_ready", 64'(req_ready), 64'd0);
    chk("init_we", 64'(rf_we), 64'd0);
    chk("init_waddr", 64'(rf_waddr), 64'd0);
    chk("init_wdata", 64'(rf_wdata), 64'd0);
    chk("init_pending", 64'(pending), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      drive(t);
      #1;
      nm = $sformatf("v%0d", i);
      chk({nm, "_ready"}, 64'(req_ready), 64'(t.e_ready));
      if (t.e_we) exp_q.push_back({t.e_waddr, t.e_wdata});
      @(posedge clk); #1;
      chk({nm, "_we"}, 64'(rf_we), 64'(t.e_we));
      chk({nm, "_waddr"}, 64'(rf_waddr), 64'(t.e_waddr));
      chk({nm, "_wdata"}, 64'(rf_wdata), 64'(t.e_wdata));
      chk({nm, "_pending"}, 64'(pending), 64'(t.e_pend));
      sb_check(nm);
    end

    // Mid-cycle asynchronous reset. ptr is now 2, so requester 2 wins first.
    req_valid = 3'b111; req_addr = A3; req_data = D3;
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    #1;
    chk("pre_rst_ready", 64'(req_ready), 64'b100);
    exp_q.push_back({5'd7, 32'hC});
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    chk("pre_rst_pending", 64'(pending), 64'h10);
    sb_check("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_we", 64'(rf_we), 64'd0);
    chk("rst_hold_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b001);
    exp_q.push_back({5'd5, 32'hA});
    @(posedge clk); #1;
    chk("post_rst_we", 64'(rf_we), 64'd1);
    chk("post_rst_waddr", 64'(rf_waddr), 64'd5);
    chk("post_rst_wdata", 64'(rf_wdata), 64'hA);
    chk("post_rst_pending", 64'(pending), 64'd0);
    sb_check("post_rst");
    chk("post_rst_next_ready", 64'(req_ready), 64'b010);
    req_valid = '0;
    @(posedge clk); #1;
    chk("idle_we", 64'(rf_we), 64'd0);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
